// File: rtl/calc_pkg.sv
// Shared opcode constants, issuer state encoding and the command legality rule
// for the 4-bit calculator command issuer.
package calc_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;

   // state      | meaning
   // ST_IDLE    | waiting for a command, cmd_ready high
   // ST_SETTLE  | calc_* driven, counting down the settle time
   // ST_RESP    | response held until the consumer takes it
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETTLE = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   // Opcodes 110/111 do not exist; div/mod by zero is screened out here so the
   // calculator never sees it.
   function automatic logic op_legal(input logic [2:0] oper, input logic [3:0] b);
      return (oper <= OP_NOT) && !(((oper == OP_DIV) || (oper == OP_MOD)) && (b == 4'd0));
   endfunction

endpackage

// File: rtl/calc_cmd_issuer.sv
// Accepts one calculator command at a time, rejects illegal ones, holds legal
// operands on the calculator for SETTLE_CYCLES and returns the captured result.
module calc_cmd_issuer
   import calc_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic [2:0]       cmd_oper,
   output logic [3:0]       calc_a,
   output logic [3:0]       calc_b,
   output logic [2:0]       calc_oper,
   input  logic [7:0]       calc_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_result,
   output logic             rsp_err,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] error_cnt
);

   localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [3:0]       settle_q, settle_d;
   logic [3:0]       calc_a_q, calc_a_d;
   logic [3:0]       calc_b_q, calc_b_d;
   logic [2:0]       calc_oper_q, calc_oper_d;
   logic [7:0]       rsp_result_q, rsp_result_d;
   logic             rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] error_q, error_d;
   logic             cmd_legal;

   assign cmd_legal = op_legal(cmd_oper, cmd_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         settle_q     <= 4'd0;
         calc_a_q     <= 4'd0;
         calc_b_q     <= 4'd0;
         calc_oper_q  <= OP_ADD;
         rsp_result_q <= 8'h00;
         rsp_err_q    <= 1'b0;
         issued_q     <= '0;
         error_q      <= '0;
      end else begin
         state_q      <= state_d;
         settle_q     <= settle_d;
         calc_a_q     <= calc_a_d;
         calc_b_q     <= calc_b_d;
         calc_oper_q  <= calc_oper_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
         issued_q     <= issued_d;
         error_q      <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cmd_valid) state_d = cmd_legal ? ST_SETTLE : ST_RESP;
         ST_SETTLE: if (settle_q == 4'd0) state_d = ST_RESP;
         ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath registers follow the FSM; everything holds unless touched here.
   always_comb begin
      settle_d     = settle_q;
      calc_a_d     = calc_a_q;
      calc_b_d     = calc_b_q;
      calc_oper_d  = calc_oper_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      issued_d     = issued_q;
      error_d      = error_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_legal) begin
                  calc_a_d    = cmd_a;
                  calc_b_d    = cmd_b;
                  calc_oper_d = cmd_oper;
                  settle_d    = SETTLE_LOAD;
                  rsp_err_d   = 1'b0;
                  if (issued_q != CNT_MAX) issued_d = issued_q + CNT_W'(1);
               end else begin
                  rsp_err_d    = 1'b1;
                  rsp_result_d = 8'h00;
                  if (error_q != CNT_MAX) error_d = error_q + CNT_W'(1);
               end
            end
         end
         ST_SETTLE: begin
            if (settle_q == 4'd0) rsp_result_d = calc_out;
            else                  settle_d     = settle_q - 4'd1;
         end
         default: ;
      endcase
   end

   always_comb begin
      cmd_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
   end

   assign calc_a     = calc_a_q;
   assign calc_b     = calc_b_q;
   assign calc_oper  = calc_oper_q;
   assign rsp_result = rsp_result_q;
   assign rsp_err    = rsp_err_q;
   assign issued_cnt = issued_q;
   assign error_cnt  = error_q;

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Bench for calc_cmd_issuer: two instances (settle 1 / 8-bit counters and
// settle 4 / 2-bit counters), each driving a behavioural calculator.
module tb_calc_cmd_issuer;

   localparam int S0 = 1;
   localparam int S1 = 4;

   logic       clk = 1'b0;
   logic       rst_n0, rst_n1;
   logic       cmd_valid0, cmd_valid1;
   logic       rsp_ready0, rsp_ready1;
   logic [3:0] cmd_a, cmd_b;
   logic [2:0] cmd_oper;

   logic       cmd_ready0, cmd_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
   logic [3:0] calc_a0, calc_b0, calc_a1, calc_b1;
   logic [2:0] calc_oper0, calc_oper1;
   logic [7:0] calc_out0, calc_out1, rsp_result0, rsp_result1;
   logic [7:0] issued0, error0;
   logic [1:0] issued1, error1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] exp_calc [2];
   int          exp_iss  [2];
   int          exp_errc [2];

   always #5 clk = ~clk;

   function automatic logic [7:0] calc_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
      logic [7:0] wa, wb;
      wa = {4'h0, a};
      wb = {4'h0, b};
      case (op)
         3'd0:    return wa + wb;
         3'd1:    return wa - wb;
         3'd2:    return wa * wb;
         3'd3:    return (b != 0) ? wa / wb : 8'h00;
         3'd4:    return (b != 0) ? wa % wb : 8'h00;
         3'd5:    return {4'h0, ~a};
         default: return 8'h00;
      endcase
   endfunction

   assign calc_out0 = calc_fn(calc_a0, calc_b0, calc_oper0);
   assign calc_out1 = calc_fn(calc_a1, calc_b1, calc_oper1);

   calc_cmd_issuer #(.SETTLE_CYCLES(S0), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper),
      .calc_a(calc_a0), .calc_b(calc_b0), .calc_oper(calc_oper0), .calc_out(calc_out0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_result(rsp_result0),
      .rsp_err(rsp_err0), .issued_cnt(issued0), .error_cnt(error0)
   );

   calc_cmd_issuer #(.SETTLE_CYCLES(S1), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_oper(cmd_oper),
      .calc_a(calc_a1), .calc_b(calc_b1), .calc_oper(calc_oper1), .calc_out(calc_out1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1),
      .rsp_err(rsp_err1), .issued_cnt(issued1), .error_cnt(error1)
   );

   function automatic logic f_rdy(int d); return (d == 0) ? cmd_ready0 : cmd_ready1; endfunction
   function automatic logic f_vld(int d); return (d == 0) ? rsp_valid0 : rsp_valid1; endfunction
   function automatic logic f_err(int d); return (d == 0) ? rsp_err0 : rsp_err1; endfunction
   function automatic logic [7:0] f_res(int d); return (d == 0) ? rsp_result0 : rsp_result1; endfunction
   function automatic logic [7:0] f_iss(int d); return (d == 0) ? issued0 : {6'h0, issued1}; endfunction
   function automatic logic [7:0] f_erc(int d); return (d == 0) ? error0 : {6'h0, error1}; endfunction
   function automatic logic [10:0] f_calc(int d);
      return (d == 0) ? {calc_a0, calc_b0, calc_oper0} : {calc_a1, calc_b1, calc_oper1};
   endfunction
   function automatic int cnt_max(int d); return (d == 0) ? 255 : 3; endfunction
   function automatic int settle(int d); return (d == 0) ? S0 : S1; endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_valid(input int d, input logic v);
      if (d == 0) cmd_valid0 = v; else cmd_valid1 = v;
   endtask

   task automatic set_rready(input int d, input logic v);
      if (d == 0) rsp_ready0 = v; else rsp_ready1 = v;
   endtask

   task automatic garbage(input int d);
      cmd_a    = 4'($urandom);
      cmd_b    = 4'($urandom);
      cmd_oper = 3'($urandom);
      set_valid(d, 1'($urandom));
   endtask

   task automatic check_reset(input int d);
      check("rst_ready", 32'(f_rdy(d)), 32'd1);
      check("rst_valid", 32'(f_vld(d)), 32'd0);
      check("rst_err", 32'(f_err(d)), 32'd0);
      check("rst_result", 32'(f_res(d)), 32'h00);
      check("rst_calc", 32'(f_calc(d)), 32'h0);
      check("rst_counts", {f_iss(d), f_erc(d)}, 32'h0);
      exp_calc[d] = '0;
      exp_iss[d]  = 0;
      exp_errc[d] = 0;
   endtask

   // One full command transaction, with `stall` cycles of response backpressure.
   task automatic run_cmd(input int d, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input int stall,
                          input logic [7:0] exp_res, input logic exp_err);
      int lat;
      check("idle_ready", 32'(f_rdy(d)), 32'd1);
      cmd_a = a; cmd_b = b; cmd_oper = op;
      set_valid(d, 1'b1);
      tick();
      garbage(d);
      if (!exp_err) begin
         exp_calc[d] = {a, b, op};
         if (exp_iss[d] < cnt_max(d)) exp_iss[d]++;
      end else if (exp_errc[d] < cnt_max(d)) exp_errc[d]++;
      check("calc_after_e0", 32'(f_calc(d)), 32'(exp_calc[d]));
      check("busy_ready", 32'(f_rdy(d)), 32'd0);
      lat = 0;
      while (!f_vld(d) && lat < 40) begin
         tick();
         garbage(d);
         lat++;
      end
      check("latency", lat, exp_err ? 0 : settle(d));
      for (int i = 0; i < stall; i++) begin
         check("stall_hold", {f_vld(d), f_rdy(d), f_err(d), f_res(d)},
               {1'b1, 1'b0, exp_err, exp_res});
         tick();
         garbage(d);
      end
      check("rsp_result", 32'(f_res(d)), 32'(exp_res));
      check("rsp_err", 32'(f_err(d)), 32'(exp_err));
      check("counters", {f_iss(d), f_erc(d)}, {8'(exp_iss[d]), 8'(exp_errc[d])});
      check("calc_hold", 32'(f_calc(d)), 32'(exp_calc[d]));
      set_valid(d, 1'b0);
      set_rready(d, 1'b1);
      tick();
      set_rready(d, 1'b0);
      check("post_hs", {f_vld(d), f_rdy(d)}, {1'b0, 1'b1});
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      int         stall;
      logic [7:0] res;
      logic       err;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] ra, rb;
      logic [2:0] rop;
      logic       rlegal, seen;

      vecs[0]  = '{4'h9, 4'h7, 3'b000, 0, 8'h10, 1'b0};
      vecs[1]  = '{4'hF, 4'h0, 3'b011, 0, 8'h00, 1'b1};
      vecs[2]  = '{4'hF, 4'h0, 3'b110, 0, 8'h00, 1'b1};
      vecs[3]  = '{4'hF, 4'hF, 3'b010, 5, 8'hE1, 1'b0};
      vecs[4]  = '{4'h3, 4'h5, 3'b001, 0, 8'hFE, 1'b0};
      vecs[5]  = '{4'h5, 4'h0, 3'b101, 1, 8'h0A, 1'b0};
      vecs[6]  = '{4'hF, 4'h4, 3'b011, 2, 8'h03, 1'b0};
      vecs[7]  = '{4'hD, 4'h4, 3'b100, 0, 8'h01, 1'b0};
      vecs[8]  = '{4'h7, 4'h0, 3'b100, 0, 8'h00, 1'b1};
      vecs[9]  = '{4'h2, 4'h3, 3'b111, 0, 8'h00, 1'b1};
      vecs[10] = '{4'h0, 4'h0, 3'b001, 0, 8'h00, 1'b0};

      rst_n0 = 1'b0; rst_n1 = 1'b0;
      cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
      rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_oper = '0;
      repeat (3) tick();
      rst_n0 = 1'b1; rst_n1 = 1'b1;
      tick();
      check_reset(0);
      check_reset(1);

      foreach (vecs[i])
         run_cmd(0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].stall, vecs[i].res, vecs[i].err);

      for (int i = 0; i < 40; i++) begin
         ra  = 4'($urandom_range(0, 15));
         rb  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         rop = 3'($urandom_range(0, 7));
         rlegal = (rop <= 3'd5) && !((rop == 3'd3 || rop == 3'd4) && rb == 4'd0);
         run_cmd(0, ra, rb, rop, $urandom_range(0, 3),
                 rlegal ? calc_fn(ra, rb, rop) : 8'h00, !rlegal);
      end

      // Reset in the middle of SETTLE on the slow instance.
      cmd_a = 4'h6; cmd_b = 4'h2; cmd_oper = 3'b010;
      cmd_valid1 = 1'b1;
      tick();
      cmd_valid1 = 1'b0;
      tick();
      tick();
      rst_n1 = 1'b0;
      #1;
      check_reset(1);
      tick();
      rst_n1 = 1'b1;
      rsp_ready1 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen = seen | rsp_valid1;
      end
      rsp_ready1 = 1'b0;
      check("no_rsp_after_rst", 32'(seen), 32'd0);
      run_cmd(1, 4'hA, 4'h3, 3'b000, 1, 8'h0D, 1'b0);

      for (int i = 0; i < 5; i++)
         run_cmd(1, 4'(i), 4'h2, 3'b010, 0, 8'(i * 2), 1'b0);
      for (int i = 0; i < 4; i++)
         run_cmd(1, 4'h1, 4'h0, 3'b011, 0, 8'h00, 1'b1);
      check("sat_issued", 32'(issued1), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
